// File: rtl/bus_pkg.sv
// Shared constants for the debug register bus and the arbiter state encoding.
// The logic-analyzer cores on the chain reuse the bus widths.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the daisy-chained debug register bus.
// One request in flight; the response is matched on addr/rw at the chain tail or times out.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] m0_addr_i,
    input  logic [BUS_ADDR_W-1:0] m1_addr_i,
    input  logic [BUS_DATA_W-1:0] m0_wdata_i,
    input  logic [BUS_DATA_W-1:0] m1_wdata_i,
    input  logic                  m0_rw_i,
    input  logic                  m1_rw_i,
    input  logic                  m0_valid_i,
    input  logic                  m1_valid_i,
    output logic                  m0_ready_o,
    output logic                  m1_ready_o,
    output logic [BUS_DATA_W-1:0] m0_rdata_o,
    output logic [BUS_DATA_W-1:0] m1_rdata_o,
    output logic                  m0_rvalid_o,
    output logic                  m1_rvalid_o,
    output logic                  m0_err_o,
    output logic                  m1_err_o,
    output logic [BUS_ADDR_W-1:0] addr_o,
    output logic [BUS_DATA_W-1:0] wdata_o,
    output logic [BUS_DATA_W-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [BUS_ADDR_W-1:0] addr_i,
    input  logic [BUS_DATA_W-1:0] wdata_i,
    input  logic [BUS_DATA_W-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic                  busy_o,
    output logic                  grant_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t            state;
    logic [TW-1:0]         timer;
    logic [BUS_ADDR_W-1:0] req_addr;
    logic                  req_rw;
    logic                  last;
    logic                  sel;
    logic                  take;
    logic                  match;
    logic                  expired;
    logic [BUS_ADDR_W-1:0] sel_addr;
    logic [BUS_DATA_W-1:0] sel_wdata;
    logic                  sel_rw;
    logic                  unused_tail;

    // On contention the master not granted last time wins; a lone requester always wins.
    assign sel        = (m0_valid_i && m1_valid_i) ? ~last : m1_valid_i;
    assign take       = (state == IDLE) && (m0_valid_i || m1_valid_i);
    assign m0_ready_o = take && !sel;
    assign m1_ready_o = take && sel;

    assign sel_addr   = sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata  = sel ? m1_wdata_i : m0_wdata_i;
    assign sel_rw     = sel ? m1_rw_i    : m0_rw_i;

    assign match      = valid_i && (addr_i == req_addr) && (rw_i == req_rw);
    assign expired    = (timer == TW'(TIMEOUT - 1));
    assign rdata_o    = '0;
    assign unused_tail = ^wdata_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            req_addr    <= '0;
            req_rw      <= 1'b0;
            last        <= 1'b1;
            addr_o      <= '0;
            wdata_o     <= '0;
            rw_o        <= 1'b0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            grant_o     <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            rw_o        <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state    <= ISSUE;
                        busy_o   <= 1'b1;
                        grant_o  <= sel;
                        last     <= sel;
                        req_addr <= sel_addr;
                        req_rw   <= sel_rw;
                        addr_o   <= sel_addr;
                        wdata_o  <= sel_wdata;
                        rw_o     <= sel_rw;
                        valid_o  <= 1'b1;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A matching beat on the expiry cycle still counts as a response.
                    if (match || expired) begin
                        state <= RESP;
                        if (grant_o) begin
                            m1_rvalid_o <= 1'b1;
                            m1_rdata_o  <= match ? rdata_i : '0;
                            m1_err_o    <= !match;
                        end else begin
                            m0_rvalid_o <= 1'b1;
                            m0_rdata_o  <= match ? rdata_i : '0;
                            m0_err_o    <= !match;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level timing model, chain responder with stray beats,
// directed scenarios with literal expectations, then a randomized run.
module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_addr_i = '0, m1_addr_i = '0, m0_wdata_i = '0, m1_wdata_i = '0;
    logic        m0_rw_i = 1'b0, m1_rw_i = 1'b0, m0_valid_i = 1'b0, m1_valid_i = 1'b0;
    logic        m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
    logic [15:0] m0_rdata_o, m1_rdata_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o, busy_o, grant_o;
    logic [15:0] addr_i = '0, wdata_i = '0, rdata_i = '0;
    logic        rw_i = 1'b0, valid_i = 1'b0;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
        .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
        .m0_rw_i(m0_rw_i), .m1_rw_i(m1_rw_i),
        .m0_valid_i(m0_valid_i), .m1_valid_i(m1_valid_i),
        .m0_ready_o(m0_ready_o), .m1_ready_o(m1_ready_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
        .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    // master request sources
    logic [1:0]  pend = '0;
    logic [15:0] r_addr [2];
    logic [15:0] r_wdata [2];
    logic        r_rw [2];
    int          auto_req = 0;

    // stimulus knobs
    int force_lat = -1, force_data = -1, stray_en = 0, stray_cyc_f = -1;
    logic rst_req = 1'b1;

    // model: one transaction descriptor plus held response registers
    bit          t_on = 0, t_m = 0, t_rw = 0, m_last = 1, e_grant = 0;
    int          t_acc = 0, t_lat = 0;
    logic [15:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    logic [15:0] e_rdata [2];
    bit          e_err [2];

    // chain responder
    int          beat_cyc = -1;
    logic [15:0] beat_addr = '0, beat_data = '0;
    logic        beat_rw = 1'b0;

    // DUT observations
    int          obs_acc = 0, obs_iss = 0, obs_rv = 0, n_valid = 0, n_rv = 0;
    bit          obs_rv_m = 0, obs_err = 0, obs_rw = 0;
    logic [15:0] obs_rd = '0, obs_wdata = '0;
    int          acc_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        t_on = 0; m_last = 1; e_grant = 0;
        e_rdata[0] = '0; e_rdata[1] = '0; e_err[0] = 0; e_err[1] = 0;
    endtask

    task automatic model_cycle();
        int rc, r;
        bit iss, rv, idle, v0, v1, w;
        rc   = t_acc + 2 + ((t_lat < TO) ? t_lat : TO);
        iss  = t_on && (cyc == t_acc + 1);
        rv   = t_on && (cyc == rc);
        idle = !t_on || (cyc > rc);
        v0   = m0_valid_i;
        v1   = m1_valid_i;
        if (iss) e_grant = t_m;
        if (rv) begin
            e_rdata[t_m] = (t_lat <= TO) ? t_rdata : 16'h0;
            e_err[t_m]   = (t_lat > TO);
        end
        chk("m0_ready", 32'(m0_ready_o), 32'(idle && v0 && (!v1 || m_last)));
        chk("m1_ready", 32'(m1_ready_o), 32'(idle && v1 && (!v0 || !m_last)));
        chk("valid_o", 32'(valid_o), 32'(iss));
        chk("addr_o", 32'(addr_o), 32'(iss ? t_addr : 16'h0));
        chk("wdata_o", 32'(wdata_o), 32'(iss ? t_wdata : 16'h0));
        chk("rw_o", 32'(rw_o), 32'(iss && t_rw));
        chk("rdata_o", 32'(rdata_o), 32'h0);
        chk("busy_o", 32'(busy_o), 32'(t_on && cyc >= t_acc + 1 && cyc <= rc));
        chk("grant_o", 32'(grant_o), 32'(e_grant));
        chk("m0_rvalid", 32'(m0_rvalid_o), 32'(rv && !t_m));
        chk("m1_rvalid", 32'(m1_rvalid_o), 32'(rv && t_m));
        chk("m0_rdata", 32'(m0_rdata_o), 32'(e_rdata[0]));
        chk("m1_rdata", 32'(m1_rdata_o), 32'(e_rdata[1]));
        chk("m0_err", 32'(m0_err_o), 32'(e_err[0]));
        chk("m1_err", 32'(m1_err_o), 32'(e_err[1]));
        if (idle && (v0 || v1)) begin
            w = (v0 && v1) ? !m_last : v1;
            m_last = w; t_on = 1; t_acc = cyc; t_m = w;
            t_addr = r_addr[w]; t_wdata = r_wdata[w]; t_rw = r_rw[w];
            if (force_lat >= 0) t_lat = force_lat;
            else begin
                r = $urandom_range(0, 9);
                if (r < 7)      t_lat = $urandom_range(1, 8);
                else if (r < 9) t_lat = $urandom_range(9, 10);
                else            t_lat = 99;
            end
            t_rdata = (force_data >= 0) ? 16'(force_data) : 16'($urandom);
            if (t_lat <= 10) begin
                beat_cyc = cyc + 1 + t_lat; beat_addr = t_addr; beat_rw = t_rw; beat_data = t_rdata;
            end
            pend[w] = 1'b0;
        end
    endtask

    task automatic observe();
        if (m0_ready_o && m0_valid_i) begin obs_acc = cyc; acc_q.push_back(0); end
        if (m1_ready_o && m1_valid_i) begin obs_acc = cyc; acc_q.push_back(1); end
        if (valid_o) begin obs_iss = cyc; obs_wdata = wdata_o; obs_rw = rw_o; n_valid++; end
        if (m0_rvalid_o) begin obs_rv = cyc; obs_rv_m = 0; obs_rd = m0_rdata_o; obs_err = m0_err_o; n_rv++; end
        if (m1_rvalid_o) begin obs_rv = cyc; obs_rv_m = 1; obs_rd = m1_rdata_o; obs_err = m1_err_o; n_rv++; end
    endtask

    task automatic gen_requests();
        for (int m = 0; m < 2; m++)
            if (auto_req != 0 && !pend[m] && (auto_req == 2 || $urandom_range(0, 2) == 0)) begin
                pend[m]    = 1'b1;
                r_addr[m]  = 16'($urandom_range(0, 7));
                r_wdata[m] = 16'($urandom);
                r_rw[m]    = 1'($urandom_range(0, 1));
            end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        #1;
        cyc++;
        rst = rst_req;
        if (rst) pend = '0;
        m0_valid_i = pend[0]; m0_addr_i = r_addr[0]; m0_wdata_i = r_wdata[0]; m0_rw_i = r_rw[0];
        m1_valid_i = pend[1]; m1_addr_i = r_addr[1]; m1_wdata_i = r_wdata[1]; m1_rw_i = r_rw[1];
        valid_i = 1'b0; addr_i = '0; rw_i = 1'b0; rdata_i = '0; wdata_i = '0;
        if (cyc == beat_cyc) begin
            valid_i = 1'b1; addr_i = beat_addr; rw_i = beat_rw; rdata_i = beat_data; wdata_i = 16'($urandom);
        end else if (cyc == stray_cyc_f) begin
            valid_i = 1'b1; addr_i = 16'h0009; rw_i = 1'b0; rdata_i = 16'hDEAD;
        end else if (stray_en != 0 && $urandom_range(0, 3) == 0) begin
            // always differs from the in-flight request in at least one address bit
            valid_i = 1'b1; addr_i = t_addr ^ (16'h1 << $urandom_range(0, 15));
            rw_i = 1'($urandom_range(0, 1)); rdata_i = 16'($urandom);
        end
        @(negedge clk);
        if (!rst) begin
            observe();
            model_cycle();
            gen_requests();
        end
    endtask

    task automatic req(input int m, input logic [15:0] a, input logic [15:0] d, input logic rw);
        pend[m] = 1'b1; r_addr[m] = a; r_wdata[m] = d; r_rw[m] = rw;
    endtask

    task automatic wait_rv(input string nm);
        int n0;
        n0 = n_rv;
        for (int i = 0; i < 60 && n_rv == n0; i++) tick();
        if (n_rv == n0) begin
            checks++; failures++;
            $display("FAIL %s: no response strobe within 60 cycles", nm);
        end
    endtask

    task automatic settle();
        int i;
        i = 0;
        while (i < 300 && (pend != 0 || busy_o || cyc <= beat_cyc)) begin tick(); i++; end
        if (i >= 300) begin
            checks++; failures++;
            $display("FAIL settle: arbiter still busy after 300 cycles");
        end
    endtask

    initial begin
        int nv0, nr0;
        r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0; r_rw[0] = 0; r_rw[1] = 0;
        e_rdata[0] = '0; e_rdata[1] = '0; e_err[0] = 0; e_err[1] = 0;

        tick(); tick();
        rst_req = 1'b0;
        tick();
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_rdata", 32'(m0_rdata_o), 32'h0);

        // contention from reset
        acc_q.delete(); nv0 = n_valid; auto_req = 2;
        for (int i = 0; i < 200 && acc_q.size() < 4; i++) tick();
        auto_req = 0;
        settle();
        chk("cont_n", 32'(acc_q.size() >= 4), 32'h1);
        if (acc_q.size() >= 4) begin
            chk("cont_g0", 32'(acc_q[0]), 32'h0);
            chk("cont_g1", 32'(acc_q[1]), 32'h1);
            chk("cont_g2", 32'(acc_q[2]), 32'h0);
            chk("cont_g3", 32'(acc_q[3]), 32'h1);
        end
        chk("cont_one_valid_each", 32'(n_valid - nv0), 32'(acc_q.size()));

        // single read, 3-cycle chain
        force_lat = 3; force_data = 16'hBEEF;
        req(0, 16'h0005, 16'h0, 1'b0);
        wait_rv("single_read");
        chk("single_issue_cyc", 32'(obs_iss - obs_acc), 32'd1);
        chk("single_rv_cyc", 32'(obs_rv - obs_acc), 32'd5);
        chk("single_master", 32'(obs_rv_m), 32'h0);
        chk("single_rdata", 32'(obs_rd), 32'hBEEF);
        chk("single_err", 32'(obs_err), 32'h0);
        settle();

        // timeout, chain silent
        force_lat = 99;
        req(0, 16'h0007, 16'h0, 1'b0);
        wait_rv("timeout");
        chk("to_rv_cyc", 32'(obs_rv - obs_acc), 32'd10);
        chk("to_err", 32'(obs_err), 32'h1);
        chk("to_rdata", 32'(obs_rd), 32'h0);
        tick();
        chk("to_idle", 32'(busy_o), 32'h0);
        settle();

        // stray beat for 0x0009 while waiting on 0x0005
        force_lat = 4; force_data = 16'h0F0F;
        req(0, 16'h0005, 16'h0, 1'b0);
        tick();
        stray_cyc_f = obs_acc + 3;
        wait_rv("mismatch");
        chk("mm_rv_cyc", 32'(obs_rv - obs_acc), 32'd6);
        chk("mm_rdata", 32'(obs_rd), 32'h0F0F);
        chk("mm_err", 32'(obs_err), 32'h0);
        stray_cyc_f = -1;
        settle();

        // write echo landing exactly on the expiry cycle
        force_lat = 8; force_data = 16'h5A5A;
        req(1, 16'h000A, 16'h1234, 1'b1);
        wait_rv("write_echo");
        chk("wr_wdata", 32'(obs_wdata), 32'h1234);
        chk("wr_rw", 32'(obs_rw), 32'h1);
        chk("wr_master", 32'(obs_rv_m), 32'h1);
        chk("wr_err", 32'(obs_err), 32'h0);
        chk("wr_rdata", 32'(obs_rd), 32'h5A5A);
        chk("wr_rv_cyc", 32'(obs_rv - obs_acc), 32'd10);
        settle();

        // reset while waiting; the late response must be dropped
        force_lat = 6; force_data = 16'h7777;
        req(1, 16'h0020, 16'h0, 1'b0);
        tick(); tick(); tick();
        rst_req = 1'b1; tick();
        rst_req = 1'b0; tick();
        chk("mrst_busy", 32'(busy_o), 32'h0);
        chk("mrst_valid", 32'(valid_o), 32'h0);
        chk("mrst_grant", 32'(grant_o), 32'h0);
        chk("mrst_m1_rdata", 32'(m1_rdata_o), 32'h0);
        nr0 = n_rv;
        for (int i = 0; i < 20 && cyc <= beat_cyc + 1; i++) tick();
        chk("mrst_no_rv", 32'(n_rv), 32'(nr0));
        acc_q.delete();
        req(0, 16'h0003, 16'h0, 1'b0);
        req(1, 16'h0004, 16'h0, 1'b0);
        tick();
        chk("mrst_m0_wins", 32'(acc_q.size() > 0 ? acc_q[0] : 9), 32'h0);
        settle();

        // randomized traffic with stray beats
        force_lat = -1; force_data = -1; auto_req = 1; stray_en = 1;
        for (int i = 0; i < 3000; i++) tick();
        auto_req = 0; stray_en = 0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
